// File: rtl/controle_programa_pkg.sv
// Shared opcodes, control encodings and FSM states for the program sequencer.
package pkg_controle;

    localparam logic [3:0] OP_CLR = 4'd0;
    localparam logic [3:0] OP_LDX = 4'd1;
    localparam logic [3:0] OP_LDY = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_HLT = 4'd5;

    typedef enum logic [1:0] {
        REG_HOLD  = 2'b00,
        REG_LOAD  = 2'b01,
        REG_CLEAR = 2'b10
    } reg_ctl_e;

    typedef enum logic [1:0] {
        ULA_ADD = 2'b00,
        ULA_SUB = 2'b01
    } ula_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_NEXT,
        S_HALT
    } state_e;

    typedef struct packed {
        reg_ctl_e tx;
        reg_ctl_e ty;
        reg_ctl_e tz;
        ula_op_e  ula;
        logic     is_alu;
        logic     is_hlt;
        logic     illegal;
    } decod_t;

endpackage

// File: rtl/controle_programa_if.sv
// Sequencer bus: run request, instruction memory port, datapath handshake and control strobes.
interface controle_programa_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic [3:0]        insControle;
    logic              dp_ready;
    logic [ADDR_W-1:0] count;
    logic [1:0]        tx;
    logic [1:0]        ty;
    logic [1:0]        tz;
    logic [1:0]        ula;
    logic              busy;
    logic              halted;
    logic              err;

    modport master (
        input  start, insControle, dp_ready,
        output count, tx, ty, tz, ula, busy, halted, err
    );

    modport slave (
        output start, insControle, dp_ready,
        input  count, tx, ty, tz, ula, busy, halted, err
    );
endinterface

// File: rtl/controle_programa_decod.sv
// Purely combinational opcode decoder: ir -> register/ULA strobes and class flags.
module decod_instrucao
    import pkg_controle::*;
(
    input  logic [3:0] ir,
    output decod_t     dec
);

    always_comb begin
        // NOTE: every field gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        dec = '{tx: REG_HOLD, ty: REG_HOLD, tz: REG_HOLD, ula: ULA_ADD,
                is_alu: 1'b0, is_hlt: 1'b0, illegal: 1'b0};
        case (ir)
            OP_CLR: begin
                dec.tx = REG_CLEAR;
                dec.ty = REG_CLEAR;
                dec.tz = REG_CLEAR;
            end
            OP_LDX: dec.tx = REG_LOAD;
            OP_LDY: dec.ty = REG_LOAD;
            OP_ADD: begin
                dec.tz     = REG_LOAD;
                dec.ula    = ULA_ADD;
                dec.is_alu = 1'b1;
            end
            OP_SUB: begin
                dec.tz     = REG_LOAD;
                dec.ula    = ULA_SUB;
                dec.is_alu = 1'b1;
            end
            OP_HLT:  dec.is_hlt  = 1'b1;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/controle_programa.sv
// Program sequencer: steps the instruction address, latches opcodes and issues one-cycle
// control strobes, stalling on the datapath handshake for ULA operations.
module controle_programa
    import pkg_controle::*;
#(
    parameter int ADDR_W   = 4,
    parameter int PROG_LEN = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    controle_programa_if.master   bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

    state_e            state_q, state_d;
    logic [3:0]        ir_q, ir_d;
    logic [ADDR_W-1:0] count_q, count_d;
    reg_ctl_e          tx_q, tx_d, ty_q, ty_d, tz_q, tz_d;
    ula_op_e           ula_q, ula_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;
    decod_t            dec;

    // ir_d equals ir_q outside FETCH, so one decoder serves both next-state and strobe logic.
    decod_instrucao u_decod (
        .ir  (ir_d),
        .dec (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            count_q  <= '0;
            tx_q     <= REG_HOLD;
            ty_q     <= REG_HOLD;
            tz_q     <= REG_HOLD;
            ula_q    <= ULA_ADD;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            ir_q     <= ir_d;
            count_q  <= count_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            tz_q     <= tz_d;
            ula_q    <= ula_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    count_d = '0;
                end
            end
            S_FETCH: begin
                ir_d    = bus.insControle;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (dec.illegal) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else if (dec.is_hlt) begin
                    state_d = S_HALT;
                end else if (dec.is_alu) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WAIT: begin
                if (bus.dp_ready) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (count_q == LAST_ADDR) begin
                    state_d = S_HALT;
                end else begin
                    count_d = count_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                if (bus.start) begin
                    err_d   = 1'b0;
                    count_d = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered strobes line up with it.
    always_comb begin
        tx_d     = REG_HOLD;
        ty_d     = REG_HOLD;
        tz_d     = REG_HOLD;
        ula_d    = ULA_ADD;
        busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC) ||
                   (state_d == S_WAIT)  || (state_d == S_NEXT);
        halted_d = (state_d == S_HALT);
        if (state_d == S_EXEC) begin
            tx_d  = dec.tx;
            ty_d  = dec.ty;
            tz_d  = dec.tz;
            ula_d = dec.ula;
        end else if (state_d == S_WAIT) begin
            ula_d = ula_q;
        end
    end

    assign bus.count  = count_q;
    assign bus.tx     = tx_q;
    assign bus.ty     = ty_q;
    assign bus.tz     = tz_q;
    assign bus.ula    = ula_q;
    assign bus.busy   = busy_q;
    assign bus.halted = halted_q;
    assign bus.err    = err_q;

endmodule
